// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types and constants for the two-port memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Requester-side and RAM-side bus bundle of the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [1:0]                   req;
  logic [1:0]                   we;
  logic [1:0][ADDR_W-1:0]       addr;
  logic [1:0][DATA_W-1:0]       wdata;
  logic [1:0][DATA_W/8-1:0]     be;
  logic [1:0]                   ack;
  logic [DATA_W-1:0]            rdata;
  logic [1:0]                   gnt;

  logic                         mem_en;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic [DATA_W/8-1:0]          mem_be;
  logic [DATA_W-1:0]            mem_rdata;

  // Arbiter side
  modport slave (
    input  req, we, addr, wdata, be, mem_rdata,
    output ack, rdata, gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Requesters plus RAM side
  modport master (
    output req, we, addr, wdata, be, mem_rdata,
    input  ack, rdata, gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational two-way round-robin pick; the port not granted
//            last wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       idx
);

  always_comb begin
    idx   = PORT_CPU;
    grant = 2'b00;
    if (req == 2'b11) begin
      idx = ~last;
    end else if (req[PORT_DMA]) begin
      idx = PORT_DMA;
    end
    if (req != 2'b00) begin
      grant = port_onehot(idx);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (CPU/DMA) arbiter in front of a single-port RAM with a
//            fixed IDLE -> ACCESS -> RESP sequence per access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);

  localparam int BE_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                mem_en_q, mem_en_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          gnt_q, gnt_d;

  logic [1:0]          win_grant;
  logic                win_idx;

  rr_arbiter u_rr (
    .req   (bus.req),
    .last  (last_q),
    .grant (win_grant),
    .idx   (win_idx)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    gnt_d    = gnt_q;
    mem_en_d = 1'b0;
    ack_d    = 2'b00;
    case (state_q)
      IDLE: begin
        gnt_d = 2'b00;
        if (bus.req != 2'b00) begin
          state_d  = ACCESS;
          owner_d  = win_idx;
          we_d     = bus.we[win_idx];
          addr_d   = bus.addr[win_idx];
          wdata_d  = bus.wdata[win_idx];
          // Loads never present byte enables to the RAM
          be_d     = bus.we[win_idx] ? bus.be[win_idx] : '0;
          gnt_d    = win_grant;
          mem_en_d = 1'b1;
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack_d   = port_onehot(owner_q);
      end
      RESP: begin
        state_d = IDLE;
        last_d  = owner_q;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= PORT_DMA;
      owner_q  <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      mem_en_q <= 1'b0;
      ack_q    <= 2'b00;
      gnt_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      mem_en_q <= mem_en_d;
      ack_q    <= ack_d;
      gnt_q    <= gnt_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.gnt       = gnt_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_en_q & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  // RAM data arrives one cycle after the strobe, i.e. exactly in RESP
  assign bus.rdata     = (state_q == RESP) ? bus.mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Scoreboard bench for mem_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mem_en_cyc = 0;
  int   mem_en_cnt = 0;

  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];
  txn_t        iss_q[$];
  txn_t        ack_q[$];
  txn_t        mon_iss;
  txn_t        mon_ack;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = i[7:0];
    return (i == 4) ? 32'hDEADBEEF : {b, 8'hA5, ~b, 8'h3C};
  endfunction

  // Behavioural single-port RAM: one-cycle read latency, byte-lane writes
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end
      bus.mem_rdata <= ram[bus.mem_addr[9:2]];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_en) begin
        mem_en_cyc = cyc;
        mem_en_cnt++;
        if (iss_q.size() == 0) begin
          check("unexpected_mem_en", 1, 0);
        end else begin
          mon_iss = iss_q.pop_front();
          check("mem_we", bus.mem_we, mon_iss.we);
          check("mem_addr", bus.mem_addr, mon_iss.addr);
          check("mem_be", bus.mem_be, mon_iss.be);
          check("gnt_access", bus.gnt, 2'b01 << mon_iss.port);
          if (mon_iss.we) check("mem_wdata", bus.mem_wdata, mon_iss.wdata);
        end
      end
      if (bus.ack != 2'b00) begin
        check("ack_onehot", $countones(bus.ack), 1);
        if (ack_q.size() == 0) begin
          check("unexpected_ack", bus.ack, 0);
        end else begin
          mon_ack = ack_q.pop_front();
          check("ack_port", bus.ack, 2'b01 << mon_ack.port);
          check("gnt_resp", bus.gnt, 2'b01 << mon_ack.port);
          if (!mon_ack.we) check("rdata", bus.rdata, mon_ack.rdata);
        end
      end
    end
  end

  task automatic present(input logic p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    txn_t t;
    bus.req[p]   = 1'b1;
    bus.we[p]    = w;
    bus.addr[p]  = a;
    bus.wdata[p] = d;
    bus.be[p]    = b;
    t.port  = p;
    t.we    = w;
    t.addr  = a;
    t.wdata = d;
    t.be    = w ? b : 4'b0000;
    t.rdata = 32'h0;
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) ref_mem[a[9:2]][8*i +: 8] = d[8*i +: 8];
      end
    end else begin
      t.rdata = ref_mem[a[9:2]];
    end
    iss_q.push_back(t);
    ack_q.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {bus.ack, bus.gnt, bus.mem_en, bus.mem_we}, 0);
    check({tag, "_addr"}, bus.mem_addr, 0);
    check({tag, "_wdata"}, bus.mem_wdata, 0);
    check({tag, "_be_rdata"}, {bus.mem_be, bus.rdata}, 0);
  endtask

  task automatic single(input logic p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input bit drop_early);
    int  t0;
    int  n;
    bit  got;
    @(posedge clk); #1;
    present(p, w, a, d, b);
    t0  = cyc;
    n   = 0;
    got = 0;
    if (drop_early) begin
      @(posedge clk); #1;
      bus.req[p] = 1'b0;
    end
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (bus.ack[p]) got = 1;
    end
    check("ack_seen", got, 1);
    if (got) begin
      check("lat_mem_en", mem_en_cyc - t0, 1);
      check("lat_ack", cyc - t0, 2);
    end
    @(posedge clk); #1;
    bus.req[p] = 1'b0;
    @(negedge clk);
    check("idle_gnt", {bus.gnt, bus.mem_en}, 0);
  endtask

  task automatic continuous();
    int   pushes;
    int   acks;
    int   prev;
    int   n;
    logic p;
    @(posedge clk); #1;
    present(1'b0, 1'b0, 32'h80, 32'h0, 4'h0);
    present(1'b1, 1'b1, 32'hC0, 32'hC0DE_0000, 4'hF);
    pushes = 2;
    acks   = 0;
    prev   = -1;
    n      = 0;
    while (acks < 8 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.ack != 2'b00) begin
        check("rr_order", bus.ack, (acks % 2 == 0) ? 2'b01 : 2'b10);
        if (prev >= 0) check("ack_gap", cyc - prev, 3);
        prev = cyc;
        acks++;
        p = bus.ack[1];
        @(posedge clk); #1;
        if (pushes < 8) begin
          if (p) present(1'b1, 1'b1, 32'hC0 + 4 * pushes, 32'hC0DE_0000 + pushes, 4'b1100);
          else   present(1'b0, 1'b0, 32'h80 + 4 * pushes, 32'h0, 4'h0);
          pushes++;
        end else begin
          bus.req[p] = 1'b0;
        end
      end
    end
    check("rr_ack_count", acks, 8);
    bus.req = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int en_before;
    for (int i = 0; i < 256; i++) begin
      ram[i]     <= init_word(i);
      ref_mem[i]  = init_word(i);
    end
    reset     = 1'b1;
    bus.req   = 2'b00;
    bus.we    = 2'b00;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.be    = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // CPU load, DMA partial store, readback, zero-lane store
    single(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    single(1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1'b0);
    single(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    single(1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    single(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
    // Requester withdraws during ACCESS
    single(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1);

    // Reset hits the ACCESS cycle of a DMA store: no ack, no reissue
    @(posedge clk); #1;
    bus.req[1]   = 1'b1;
    bus.we[1]    = 1'b1;
    bus.addr[1]  = 32'h30;
    bus.wdata[1] = 32'hBAD0_BAD0;
    bus.be[1]    = 4'hF;
    @(posedge clk); #1;
    check("abort_in_access", bus.mem_en, 1);
    reset   = 1'b1;
    bus.req = 2'b00;
    #1;
    check("abort_mem_en", {bus.mem_en, bus.mem_we}, 0);
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    en_before = mem_en_cnt;
    repeat (6) @(negedge clk);
    check("post_abort_idle", mem_en_cnt - en_before, 0);
    single(1'b0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0);

    // Fresh reset so the first tie goes to the CPU, then saturate both ports
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    continuous();
    repeat (4) @(negedge clk);
    check("scoreboard_drained", iss_q.size() + ack_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the data width; DATA_W/8 SHALL be the byte-enable width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  2  per-port access request; bit 0 = CPU, bit 1 = DMA.
REQ-007 we  input  2  per-port write enable (1 = store, 0 = load).
REQ-008 addr  input  2 x ADDR_W  per-port byte address.
REQ-009 wdata  input  2 x DATA_W  per-port write data.
REQ-010 be  input  2 x DATA_W/8  per-port byte enables (SB/SH/SW lanes).
REQ-011 ack  output  2  per-port one-cycle completion pulse.
REQ-012 rdata  output  DATA_W  load data, common to both ports, valid only while the port's ack bit is 1.
REQ-013 gnt  output  2  one-hot current owner; all-zero when idle.
REQ-014 mem_en, mem_we  output  1 each  single-port RAM strobe and write enable.
REQ-015 mem_addr, mem_wdata, mem_be  output  ADDR_W, DATA_W, DATA_W/8  RAM address, write data and byte enables.
REQ-016 mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_en.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-018 Transitions SHALL be IDLE->ACCESS when any req bit is 1, ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-019 In IDLE, the winner SHALL be chosen combinationally, and its index and its we, addr, wdata and be SHALL be registered on the IDLE->ACCESS edge.
REQ-020 Arbitration SHALL be round-robin: with both req bits 1, the port not granted last SHALL win; with one req bit 1, that port SHALL win.
REQ-021 In ACCESS, mem_en SHALL be 1 for exactly one cycle, and mem_we, mem_addr, mem_wdata and mem_be SHALL come from the latched registers.
REQ-022 In RESP, ack SHALL be 1 for the latched owner only, and rdata SHALL equal mem_rdata.
REQ-023 In RESP, last-granted SHALL update to the owner.
REQ-024 gnt SHALL be one-hot for the owner during ACCESS and RESP.
REQ-025 Latency SHALL be fixed: req seen in IDLE at cycle N -> mem_en at N+1 -> ack at N+2; peak throughput SHALL be one access per 3 cycles.
REQ-026 Requester protocol: req, we, addr, wdata and be SHALL be held until ack, and req SHALL be dropped or re-presented on the edge after ack.
REQ-027 If req drops during ACCESS or RESP, the access SHALL still complete and ack SHALL still pulse.
REQ-028 A write with be = 0 SHALL still issue mem_en/mem_we with mem_be = 0 and SHALL still return ack.
REQ-029 On reads, mem_we and mem_be SHALL be 0.
REQ-030 Outside ACCESS, mem_en and mem_we SHALL be 0.

Reset
REQ-031 On reset, state SHALL be IDLE.
REQ-032 On reset, last-granted SHALL be port 1, so port 0 wins the first tie.
REQ-033 On reset, all latched registers SHALL be 0.
REQ-034 During reset, ack, gnt, mem_en and mem_we SHALL be 0, and mem_addr, mem_wdata, mem_be and rdata SHALL be 0.
REQ-035 Reset asserted mid-ACCESS or mid-RESP SHALL abort the access with no ack, and a write already issued SHALL NOT be reissued.

Structure
REQ-036 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RESP) and the constants PORT_CPU = 0 and PORT_DMA = 1.
REQ-037 Sub-module rr_arbiter SHALL be combinational, with inputs req[1:0] and last, and outputs a one-hot grant and an index.
REQ-038 All registers SHALL live in mem_arbiter.

Verification
REQ-039 After reset, CPU reads addr 0x10 while the RAM holds 0xDEADBEEF -> mem_en at +1 with mem_we = 0; ack[0] and rdata = 0xDEADBEEF at +2.
REQ-040 DMA writes addr 0x20 with wdata 0x12345678 and be = 4'b0011 -> mem_we = 1 and mem_be = 4'b0011 at +1; ack[1] at +2; a later read returns 0x????5678 with the upper bytes unchanged.
REQ-041 Both ports request continuously -> grants alternate CPU, DMA, CPU, DMA, with ack every 3 cycles and never two ack bits at once.
REQ-042 Both ports request in the first cycle after reset -> CPU wins first.
REQ-043 CPU drops req during ACCESS -> ack[0] still pulses in RESP and the FSM returns to IDLE.
REQ-044 Reset is asserted in the ACCESS cycle of a DMA write -> no ack; after release, mem_en stays 0 until a new req arrives.
